// File: rtl/axis_cobs_encode.sv
// AXI4-Stream COBS encoder.
// Raw tlast-delimited byte frames in, COBS-encoded frames out. Each run of up
// to 254 non-zero bytes is held in a segment buffer so that its code byte can
// be emitted ahead of the data. Input is only accepted while a segment is being
// filled; the output side then drains code, data, and any trailing bytes.
module axis_cobs_encode #(
  parameter bit APPEND_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_CODE = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_POST = 2'd3;

  localparam logic [1:0] NXT_NONE  = 2'd0;
  localparam logic [1:0] NXT_DATA  = 2'd1;
  localparam logic [1:0] NXT_FINAL = 2'd2;
  localparam logic [1:0] NXT_DELIM = 2'd3;

  localparam logic [7:0] SEG_MAX = 8'd254;

  logic [1:0] state;
  logic [7:0] cnt;
  logic [7:0] rd_ptr;
  logic       frame_end;
  logic       need_final;
  logic       err;
  logic       post_delim;
  logic       s_rdy;

  logic [7:0] tdata_p0;
  logic       vld_p0;
  logic       tlast_p0;
  logic       tuser_p0;

  logic [7:0] seg_buf [0:253];

  logic       acc;
  logic       is_zero;
  logic [7:0] cnt_inc;
  logic [7:0] cnt_new;
  logic       close;
  logic       last_code;
  logic       m_fire;
  logic [7:0] rd_data;
  logic       last_data;
  logic [1:0] nxt_sel;

  // A segment of n stored bytes is announced by code n+1 (0xFF for a full run).
  function automatic logic [7:0] code_byte(input logic [7:0] count);
    return count + 8'd1;
  endfunction

  assign acc     = s_rdy && s_axis_tvalid;
  assign is_zero = (s_axis_tdata == 8'h00);
  assign cnt_inc = cnt + 8'd1;
  assign cnt_new = is_zero ? cnt : cnt_inc;
  assign close   = is_zero || s_axis_tlast || (cnt_inc == SEG_MAX);

  // A closing code byte is frame-final only for an empty segment ending the
  // frame without a trailing 0x01; a tlast zero always adds that 0x01.
  assign last_code = !APPEND_ZERO && s_axis_tlast && !is_zero && (cnt_new == 8'd0);

  assign m_fire    = vld_p0 && m_axis_tready;
  assign rd_data   = seg_buf[rd_ptr];
  assign last_data = !APPEND_ZERO && frame_end && !need_final && ((rd_ptr + 8'd1) == cnt);

  // Decide which byte follows the one currently on the output.
  always_comb begin
    nxt_sel = NXT_NONE;
    if (state == S_CODE || state == S_DATA) begin
      if (rd_ptr != cnt) begin
        nxt_sel = NXT_DATA;
      end else if (need_final) begin
        nxt_sel = NXT_FINAL;
      end else if (frame_end && APPEND_ZERO) begin
        nxt_sel = NXT_DELIM;
      end
    end else if (state == S_POST) begin
      if (!post_delim && frame_end && APPEND_ZERO) begin
        nxt_sel = NXT_DELIM;
      end
    end
  end

  // Segment buffer write: non-zero input bytes are stored in arrival order.
  always_ff @(posedge clk) begin
    if (acc && !is_zero) begin
      seg_buf[cnt] <= s_axis_tdata;
    end
  end

  // Control FSM and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      cnt        <= 8'd0;
      rd_ptr     <= 8'd0;
      frame_end  <= 1'b0;
      need_final <= 1'b0;
      err        <= 1'b0;
      post_delim <= 1'b0;
      s_rdy      <= 1'b0;
      vld_p0     <= 1'b0;
      tdata_p0   <= 8'h00;
      tlast_p0   <= 1'b0;
      tuser_p0   <= 1'b0;
    end else if (state == S_FILL) begin
      s_rdy <= 1'b1;
      if (acc) begin
        cnt <= cnt_new;
        if (close) begin
          s_rdy      <= 1'b0;
          state      <= S_CODE;
          vld_p0     <= 1'b1;
          tdata_p0   <= code_byte(cnt_new);
          tlast_p0   <= last_code;
          tuser_p0   <= last_code && s_axis_tuser;
          frame_end  <= s_axis_tlast;
          need_final <= s_axis_tlast && is_zero;
          err        <= s_axis_tlast && s_axis_tuser;
        end
      end
    end else if (m_fire) begin
      case (nxt_sel)
        NXT_DATA: begin
          state    <= S_DATA;
          tdata_p0 <= rd_data;
          tlast_p0 <= last_data;
          tuser_p0 <= last_data && err;
          rd_ptr   <= rd_ptr + 8'd1;
        end
        NXT_FINAL: begin
          state      <= S_POST;
          post_delim <= 1'b0;
          need_final <= 1'b0;
          tdata_p0   <= 8'h01;
          tlast_p0   <= !APPEND_ZERO;
          tuser_p0   <= !APPEND_ZERO && err;
        end
        NXT_DELIM: begin
          state      <= S_POST;
          post_delim <= 1'b1;
          tdata_p0   <= 8'h00;
          tlast_p0   <= 1'b1;
          tuser_p0   <= err;
        end
        default: begin
          state      <= S_FILL;
          vld_p0     <= 1'b0;
          tlast_p0   <= 1'b0;
          tuser_p0   <= 1'b0;
          cnt        <= 8'd0;
          rd_ptr     <= 8'd0;
          frame_end  <= 1'b0;
          need_final <= 1'b0;
          err        <= 1'b0;
          post_delim <= 1'b0;
          s_rdy      <= 1'b1;
        end
      endcase
    end
  end

  assign s_axis_tready = s_rdy;
  assign m_axis_tdata  = tdata_p0;
  assign m_axis_tvalid = vld_p0;
  assign m_axis_tlast  = tlast_p0;
  assign m_axis_tuser  = tuser_p0;

endmodule

// File: tb/tb_axis_cobs_encode.sv
// Testbench for axis_cobs_encode: two instances (APPEND_ZERO=1 and 0) driven
// independently, with expected encodings from a frame-level COBS model pushed
// to per-instance queues and popped by output monitors.
module tb_axis_cobs_encode;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_tdata  [2];
  logic       s_tvalid [2];
  logic       s_tready [2];
  logic       s_tlast  [2];
  logic       s_tuser  [2];
  logic [7:0] m_tdata  [2];
  logic       m_tvalid [2];
  logic       m_tready [2];
  logic       m_tlast  [2];
  logic       m_tuser  [2];

  exp_t exp_q [2][$];
  bit   rdy_auto [2];
  int   rdy_pct;
  int   gap_pct;
  int   n_checks;
  int   n_pass;
  int   timeouts;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_cobs_encode #(.APPEND_ZERO(g == 0)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axis_tdata (s_tdata[g]),
      .s_axis_tvalid(s_tvalid[g]),
      .s_axis_tready(s_tready[g]),
      .s_axis_tlast (s_tlast[g]),
      .s_axis_tuser (s_tuser[g]),
      .m_axis_tdata (m_tdata[g]),
      .m_axis_tvalid(m_tvalid[g]),
      .m_axis_tready(m_tready[g]),
      .m_axis_tlast (m_tlast[g]),
      .m_axis_tuser (m_tuser[g])
    );

    // Random output backpressure.
    initial begin
      m_tready[g] = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (rdy_auto[g]) m_tready[g] = ($urandom_range(99) < rdy_pct);
      end
    end

    // Output monitor: compare every handshake, and check stability while stalled.
    initial begin
      bit         prev_stall;
      logic [9:0] prev;
      exp_t       e;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (prev_stall) begin
            check($sformatf("dut%0d stall hold", g),
                  {21'd0, m_tvalid[g], m_tdata[g], m_tlast[g], m_tuser[g]},
                  {21'd0, 1'b1, prev});
          end
          if (m_tvalid[g] && m_tready[g]) begin
            check($sformatf("dut%0d byte expected", g), (exp_q[g].size() != 0), 1);
            if (exp_q[g].size() != 0) begin
              e = exp_q[g].pop_front();
              check($sformatf("dut%0d tdata", g), m_tdata[g], e.d);
              check($sformatf("dut%0d tlast", g), m_tlast[g], e.l);
              check($sformatf("dut%0d tuser", g), m_tuser[g], e.u);
            end
          end
          prev_stall = m_tvalid[g] && !m_tready[g];
          prev       = {m_tdata[g], m_tlast[g], m_tuser[g]};
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Textbook COBS over a whole frame: split at zeros, cap blocks at 254 bytes,
  // and omit the final block when the frame ends exactly on a full block.
  function automatic bq_t cobs_model(input bq_t fr);
    bq_t enc;
    bq_t seg;
    bit  full_end;
    enc = {};
    seg = {};
    full_end = 1'b0;
    foreach (fr[i]) begin
      full_end = 1'b0;
      if (fr[i] == 8'h00) begin
        enc.push_back(8'(seg.size() + 1));
        enc = {enc, seg};
        seg = {};
      end else begin
        seg.push_back(fr[i]);
        if (seg.size() == 254) begin
          enc.push_back(8'hFF);
          enc = {enc, seg};
          seg = {};
          full_end = 1'b1;
        end
      end
    end
    if (!full_end) begin
      enc.push_back(8'(seg.size() + 1));
      enc = {enc, seg};
    end
    return enc;
  endfunction

  task automatic drive_beat(input int d, input logic [7:0] b, input logic l, input logic u);
    bit acc;
    int waitc;
    if (timeouts > 2) return;
    if ($urandom_range(99) < gap_pct) begin
      s_tvalid[d] = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    s_tdata[d]  = b;
    s_tlast[d]  = l;
    s_tuser[d]  = u;
    s_tvalid[d] = 1'b1;
    acc   = 1'b0;
    waitc = 0;
    while (!acc && waitc < 5000) begin
      @(negedge clk);
      acc = s_tready[d];
      @(posedge clk);
      #1;
      waitc++;
    end
    s_tvalid[d] = 1'b0;
    s_tlast[d]  = 1'b0;
    if (!acc) timeouts++;
  endtask

  task automatic send_frame(input int d, input bq_t fr, input logic user);
    bq_t  enc;
    exp_t loc [$];
    exp_t e;
    enc = cobs_model(fr);
    loc = {};
    foreach (enc[i]) begin
      e.d = enc[i];
      e.l = 1'b0;
      e.u = 1'b0;
      loc.push_back(e);
    end
    if (d == 0) begin
      e.d = 8'h00;
      e.l = 1'b1;
      e.u = user;
      loc.push_back(e);
    end else begin
      e = loc[loc.size() - 1];
      e.l = 1'b1;
      e.u = user;
      loc[loc.size() - 1] = e;
    end
    foreach (loc[i]) exp_q[d].push_back(loc[i]);
    foreach (fr[i]) begin
      if (i == fr.size() - 1) drive_beat(d, fr[i], 1'b1, user);
      else drive_beat(d, fr[i], 1'b0, 1'($urandom_range(1)));
    end
  endtask

  task automatic run_directed(input int d);
    bq_t f;
    f = '{8'h11, 8'h22, 8'h00, 8'h33};
    send_frame(d, f, 1'b0);
    f = '{8'h00};
    send_frame(d, f, 1'b0);
    f = '{8'h00, 8'h00};
    send_frame(d, f, 1'b1);
    f = {};
    for (int i = 1; i <= 254; i++) f.push_back(8'(i));
    send_frame(d, f, 1'b0);
    f.push_back(8'hFF);
    send_frame(d, f, 1'b1);
    f.delete();
    for (int i = 1; i <= 254; i++) f.push_back(8'(i));
    f.push_back(8'h00);
    send_frame(d, f, 1'b0);
    f = '{8'h11, 8'h22};
    send_frame(d, f, 1'b1);
    f = '{8'h11, 8'h00};
    send_frame(d, f, 1'b0);
  endtask

  task automatic run_random(input int d, input int nframes);
    bq_t f;
    int  len;
    int  zpct;
    for (int k = 0; k < nframes; k++) begin
      f = {};
      if ($urandom_range(49) == 0) begin
        len  = $urandom_range(250, 520);
        zpct = ($urandom_range(1) == 0) ? 0 : 2;
      end else begin
        len  = $urandom_range(1, 16);
        zpct = 25;
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(99) < zpct) f.push_back(8'h00);
        else f.push_back(8'($urandom_range(1, 255)));
      end
      send_frame(d, f, 1'($urandom_range(1)));
    end
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && c < 20000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, " dut0 pending"}, exp_q[0].size(), 0);
    check({tag, " dut1 pending"}, exp_q[1].size(), 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check({tag, " dut0 idle tvalid"}, m_tvalid[0], 0);
    check({tag, " dut1 idle tvalid"}, m_tvalid[1], 0);
  endtask

  task automatic reset_checks(input int d, input string tag);
    check($sformatf("%s dut%0d s_tready", tag, d), s_tready[d], 0);
    check($sformatf("%s dut%0d m_tvalid", tag, d), m_tvalid[d], 0);
    check($sformatf("%s dut%0d m_tdata", tag, d), m_tdata[d], 0);
    check($sformatf("%s dut%0d m_tlast", tag, d), m_tlast[d], 0);
    check($sformatf("%s dut%0d m_tuser", tag, d), m_tuser[d], 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t f;
    n_checks = 0;
    n_pass   = 0;
    timeouts = 0;
    rdy_pct  = 100;
    gap_pct  = 0;
    rst_n    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rdy_auto[d] = 1'b1;
      s_tdata[d]  = 8'h00;
      s_tvalid[d] = 1'b0;
      s_tlast[d]  = 1'b0;
      s_tuser[d]  = 1'b0;
    end
    #2 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) reset_checks(d, "por");
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;

    fork
      run_directed(0);
      run_directed(1);
    join
    drain("directed");

    rdy_pct = 75;
    gap_pct = 25;
    fork
      run_random(0, 1000);
      run_random(1, 1000);
    join
    drain("random");

    // Abort a frame while its data bytes are being sent.
    rdy_pct = 100;
    gap_pct = 0;
    rdy_auto[0] = 1'b0;
    m_tready[0] = 1'b0;
    f = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(0, f, 1'b0);
    check("pre-abort code valid", m_tvalid[0], 1);
    m_tready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m_tready[0] = 1'b0;
    check("pre-abort data byte", m_tdata[0], 8'h22);
    #2 rst_n = 1'b0;
    #1;
    reset_checks(0, "mid-data");
    exp_q[0].delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_auto[0] = 1'b1;
    f = '{8'hAA};
    send_frame(0, f, 1'b0);
    drain("post-abort");

    check("input accept timeouts", timeouts, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_cobs_encode.md
Name: axis_cobs_encode

Overview:
- AXI4-Stream COBS encoder: 8-bit frames in (tlast-delimited), COBS-encoded frames out, optionally terminated by a 0x00 delimiter.
- It is the transmit-side counterpart of the COBS decoder.
- Each segment of up to 254 non-zero bytes is buffered internally so the code byte can be sent ahead of the data.

Parameters:
- APPEND_ZERO, 1: 1 appends a 0x00 delimiter after each encoded frame, with tlast on that byte. 0 puts tlast on the final encoded byte.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  8  raw frame byte
- s_axis_tvalid  input  1  input valid
- s_axis_tready  output  1  input ready
- s_axis_tlast  input  1  last byte of raw frame
- s_axis_tuser  input  1  frame error flag, sampled on the tlast beat
- m_axis_tdata  output  8  encoded byte
- m_axis_tvalid  output  1  output valid
- m_axis_tready  input  1  output ready
- m_axis_tlast  output  1  last byte of encoded frame
- m_axis_tuser  output  1  error flag, valid with m_axis_tlast

Behaviour:
- Reset:
  - One clock domain; rst_n is asynchronous, active-low.
  - While rst_n=0: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0; state=FILL; count=0; rd_ptr=0; flags cleared.
  - Segment buffer contents are don't-care.
  - Reset mid-frame discards the partial frame. The first beat after release starts a new frame.
- Storage: 254x8 segment buffer, 8-bit count n (0..254), read pointer, flags last_seg, frame_end, err.
- FILL:
  - s_axis_tready=1.
  - On an accepted non-zero byte: write buf[n], n++.
  - Segment close conditions:
    - Accepted zero byte: not stored; code=n+1.
    - n reaches 254 on a non-zero byte: code=0xFF; no implied zero.
    - tlast: code=n+1 (or 0xFF if the 254th byte).
  - On close: s_axis_tready drops the next cycle; go to CODE.
  - If tlast: latch frame_end=1 and err=s_axis_tuser.
  - If the tlast byte is 0x00: also set need_final=1 (a trailing 0x01 segment is required).
- CODE:
  - Present code byte; m_axis_tvalid rises the cycle after the closing input beat.
  - On handshake, go to DATA if n>0, else POST.
- DATA:
  - Present buf[rd_ptr] in order; advance on each handshake.
  - After byte n-1, go to POST.
- POST:
  - If need_final: emit 0x01, clear need_final.
  - Else if frame_end and APPEND_ZERO=1: emit 0x00 with tlast=1, tuser=err.
  - Else if frame_end and APPEND_ZERO=0: tlast/tuser were already applied to the last emitted byte; this state is pass-through.
  - Then clear n, rd_ptr, flags; go to FILL.
- Last-byte rule for APPEND_ZERO=0: tlast/tuser go on whichever byte is last: the final data byte, a code byte with n=0, or the trailing 0x01.
- Handshake:
  - m_axis_tdata/tlast/tuser are registered and held stable while tvalid=1 and tready=0.
  - Zero bubbles between encoded bytes under continuous tready.
  - No input accepted outside FILL; throughput is reduced by design.
- Boundaries:
  - 254 non-zero bytes with tlast on the 254th: FF + data, no trailing 0x01.
  - Zero immediately after a 0xFF segment: encodes as code 0x01.
  - Back-to-back zeros: each yields 0x01.
  - s_axis_tuser is ignored except on the tlast beat.

Test Plan:
- 11 22 00 33 (tlast on 33), APPEND_ZERO=1 -> 03 11 22 02 33 00; tlast on 00, tuser=0.
- Single 00 with tlast -> 01 01 00. Input 00 00 with tlast -> 01 01 01 00.
- 254 bytes 01..FE with tlast -> FF 01..FE 00.
- 255 bytes 01..FF with tlast -> FF 01..FE 02 FF 00.
- 254 non-zero bytes then 00 with tlast -> FF 01..FE 01 01 00.
- 11 22 with tlast and tuser=1 -> 03 11 22 00, tuser=1 on 00.
- Same frame with APPEND_ZERO=0 -> 03 11 22, tlast/tuser on 22.
- Random m_axis_tready and s_axis_tvalid gaps over 1000 random frames -> output identical to a software COBS model; data stable while stalled.
- Feeding the output to the COBS decoder round-trips the input frames.
- Assert rst_n=0 mid-DATA -> outputs and s_axis_tready zero immediately, without waiting for a clock edge.
- After release, frame AA -> 02 AA 00 with no residue from the aborted frame.
